// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: PC-select codes, NOP word and
// the fetch-stage state encoding, plus the j/jal target formation helper.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_J   = 2'b01;
    localparam logic [1:0] PCSEL_JR  = 2'b10;
    localparam logic [1:0] PCSEL_BR  = 2'b11;

    localparam word_t NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // j/jal stay inside the 256 MB region of the delay-slot PC.
    function automatic word_t jump_addr(input logic [3:0] region, input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage boundary: instruction memory, ID-stage redirect controls,
// hazard stall, and the IF/ID register plus halt/done status.
interface pc_fetch_stage_if;
    import mips_pkg::*;

    logic       stall;
    word_t      imem_data;
    logic [1:0] pc_sel;
    word_t      jump_target;
    word_t      jr_value;
    word_t      branch_target;
    word_t      imem_addr;
    word_t      if_id_instr;
    word_t      if_id_pc4;
    logic       halted;
    logic       done;

    modport master (
        input  stall, imem_data, pc_sel, jump_target, jr_value, branch_target,
        output imem_addr, if_id_instr, if_id_pc4, halted, done
    );

    modport slave (
        output stall, imem_data, pc_sel, jump_target, jr_value, branch_target,
        input  imem_addr, if_id_instr, if_id_pc4, halted, done
    );

endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: sequential pc+4, j/jal, jr or taken branch.
module next_pc_mux
    import mips_pkg::*;
(
    input  word_t       pc,
    input  logic [3:0]  pc4_region,
    input  logic [1:0]  pc_sel,
    input  logic [25:0] jump_index,
    input  word_t       jr_value,
    input  word_t       branch_target,
    output word_t       pc_plus4,
    output word_t       next_pc
);

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        // NOTE: default assignment first so no path leaves next_pc unassigned (no latch).
        next_pc = pc_plus4;
        case (pc_sel)
            PCSEL_J:  next_pc = jump_addr(pc4_region, jump_index);
            PCSEL_JR: next_pc = jr_value;
            PCSEL_BR: next_pc = branch_target;
            default:  next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID register, and the
// halt-word detector that drains the pipeline before raising done.
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter word_t       RESET_PC     = 32'h0000_0000,
    parameter word_t       HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RESET_n,
    pc_fetch_stage_if.master   bus
);

    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    word_t            pc;
    word_t            id_instr;
    word_t            id_pc4;
    logic [1:0]       state;
    logic [CNT_W-1:0] drain_cnt;
    logic             is_halted;
    logic             is_done;
    word_t            pc_plus4;
    word_t            next_pc;

    next_pc_mux u_next_pc_mux (
        .pc            (pc),
        .pc4_region    (id_pc4[31:28]),
        .pc_sel        (bus.pc_sel),
        .jump_index    (bus.jump_target[25:0]),
        .jr_value      (bus.jr_value),
        .branch_target (bus.branch_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    assign bus.imem_addr   = pc;
    assign bus.if_id_instr = id_instr;
    assign bus.if_id_pc4   = id_pc4;
    assign bus.halted      = is_halted;
    assign bus.done        = is_done;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            // NOTE: every register gets an explicit reset value so nothing powers up as X.
            pc        <= RESET_PC;
            id_instr  <= NOP_INSTR;
            id_pc4    <= '0;
            state     <= RUN;
            drain_cnt <= '0;
            is_halted <= 1'b0;
            is_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                RUN: begin
                    if (bus.stall) begin
                        pc       <= pc;
                    end else if (id_instr == HALT_INSTR) begin
                        id_instr  <= NOP_INSTR;
                        drain_cnt <= CNT_W'(1);
                        is_halted <= 1'b1;
                        state     <= DRAIN;
                    end else if (bus.pc_sel != PCSEL_SEQ) begin
                        // Flush the wrong-path fetch: one bubble per taken redirect.
                        pc       <= next_pc;
                        id_instr <= NOP_INSTR;
                        id_pc4   <= '0;
                    end else begin
                        pc       <= next_pc;
                        id_instr <= bus.imem_data;
                        id_pc4   <= pc_plus4;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == CNT_W'(DRAIN_CYCLES)) begin
                        is_done <= 1'b1;
                        state   <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    is_done <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed scoreboard bench for pc_fetch_stage: stimulus pushes expected
// IF outputs, an independent monitor pops and compares them.
module tb_pc_fetch_stage;
    import mips_pkg::*;

    typedef struct {
        string name;
        word_t addr;
        word_t instr;
        word_t pc4;
        logic  chk_pc4;
        logic  halted;
        logic  done;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    word_t halt_addr = 32'h7000_0404;
    exp_t  sb[$];
    int    n_compared = 0;
    int    n_mismatched = 0;
    event  sample_ev;

    always #5 clk = ~clk;

    pc_fetch_stage_if bus ();

    pc_fetch_stage dut (
        .CLK     (clk),
        .RESET_n (rst_n),
        .bus     (bus)
    );

    function automatic word_t imem_word(input word_t a, input word_t h);
        if (a == 32'h0) return 32'h2001_0005;
        if (a == h) return 32'hFFFF_FFFF;
        return a ^ 32'h5A5A_0000;
    endfunction

    always_comb bus.imem_data = imem_word(bus.imem_addr, halt_addr);

    task automatic check(input string name, input word_t act, input word_t exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string n, input word_t addr, input word_t instr,
                              input word_t pc4, input logic chk, input logic h, input logic d);
        exp_t e;
        e.name = n; e.addr = addr; e.instr = instr; e.pc4 = pc4;
        e.chk_pc4 = chk; e.halted = h; e.done = d;
        sb.push_back(e);
    endtask

    // Drive one cycle of ID controls, queue the post-edge expectation, advance.
    task automatic step(input logic [1:0] sel, input word_t tgt, input logic st, input string n,
                        input word_t addr, input word_t instr, input word_t pc4,
                        input logic chk, input logic h, input logic d);
        bus.pc_sel        = sel;
        bus.stall         = st;
        bus.jump_target   = (sel == PCSEL_J)  ? tgt : 32'h0000_0BAD;
        bus.jr_value      = (sel == PCSEL_JR) ? tgt : 32'h0000_0C00;
        bus.branch_target = (sel == PCSEL_BR) ? tgt : 32'h0000_0D00;
        expect_out(n, addr, instr, pc4, chk, h, d);
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".imem_addr"}, bus.imem_addr, e.addr);
                check({e.name, ".if_id_instr"}, bus.if_id_instr, e.instr);
                if (e.chk_pc4) check({e.name, ".if_id_pc4"}, bus.if_id_pc4, e.pc4);
                check({e.name, ".halted"}, {31'b0, bus.halted}, {31'b0, e.halted});
                check({e.name, ".done"}, {31'b0, bus.done}, {31'b0, e.done});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.stall = 1'b0; bus.pc_sel = PCSEL_SEQ;
        bus.jump_target = '0; bus.jr_value = '0; bus.branch_target = '0;

        repeat (2) @(negedge clk);
        #2;
        expect_out("reset", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        step(PCSEL_SEQ, 32'h0, 1'b0, "fetch0", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "fetch1", 32'h8, 32'h5A5A_0004, 32'h8, 1'b1, 1'b0, 1'b0);
        step(PCSEL_J, 32'h40, 1'b0, "jump", 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "after_jump", 32'h104, 32'h5A5A_0100, 32'h104, 1'b1, 1'b0, 1'b0);
        step(PCSEL_JR, 32'h200, 1'b1, "stall0", 32'h104, 32'h5A5A_0100, 32'h104, 1'b1, 1'b0, 1'b0);
        step(PCSEL_JR, 32'h200, 1'b1, "stall1", 32'h104, 32'h5A5A_0100, 32'h104, 1'b1, 1'b0, 1'b0);
        step(PCSEL_JR, 32'h200, 1'b0, "jr", 32'h200, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(PCSEL_JR, 32'hFFFF_FFF8, 1'b0, "jr_high", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "seq_top", 32'hFFFF_FFFC, 32'hA5A5_FFF8, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "wrap", 32'h0, 32'hA5A5_FFFC, 32'h0, 1'b1, 1'b0, 1'b0);
        step(PCSEL_BR, 32'h3C, 1'b0, "branch", 32'h3C, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "after_branch", 32'h40, 32'h5A5A_003C, 32'h40, 1'b1, 1'b0, 1'b0);
        step(PCSEL_JR, 32'h7000_0010, 1'b0, "jr_region", 32'h7000_0010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "seq_region", 32'h7000_0014, 32'h2A5A_0010, 32'h7000_0014, 1'b1, 1'b0, 1'b0);
        step(PCSEL_J, 32'hFC00_0100, 1'b0, "jump_region", 32'h7000_0400, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "pre_halt0", 32'h7000_0404, 32'h2A5A_0400, 32'h7000_0404, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "pre_halt1", 32'h7000_0408, 32'hFFFF_FFFF, 32'h7000_0408, 1'b1, 1'b0, 1'b0);
        step(PCSEL_BR, 32'h80, 1'b0, "halt", 32'h7000_0408, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_J, 32'h10, 1'b1, "drain1", 32'h7000_0408, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_JR, 32'h500, 1'b0, "drain2", 32'h7000_0408, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_BR, 32'h600, 1'b1, "drain3", 32'h7000_0408, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "drain4_done", 32'h7000_0408, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(PCSEL_BR, 32'h700, 1'b0, "done_hold", 32'h7000_0408, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

        halt_addr = 32'h8;
        rst_n = 1'b0;
        expect_out("reset_from_done", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        step(PCSEL_SEQ, 32'h0, 1'b0, "run2_0", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "run2_1", 32'h8, 32'h5A5A_0004, 32'h8, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "run2_2", 32'hC, 32'hFFFF_FFFF, 32'hC, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "halt2", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "drain2_1", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Reset pulse entirely between clock edges, sampled before it releases.
        rst_n = 1'b0;
        expect_out("async_reset", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        -> sample_ev;
        #2;
        rst_n = 1'b1;

        step(PCSEL_SEQ, 32'h0, 1'b0, "restart0", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "restart1", 32'h8, 32'h5A5A_0004, 32'h8, 1'b1, 1'b0, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "restart2", 32'hC, 32'hFFFF_FFFF, 32'hC, 1'b1, 1'b0, 1'b0);
        step(PCSEL_J, 32'h20, 1'b0, "halt3", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "drain3_1", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "drain3_2", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "drain3_3", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(PCSEL_SEQ, 32'h0, 1'b0, "drain3_done", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
